// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the squash bubble word, LEGv8 opcode match
// constants used by both fetch and control, the fetch FSM state type and
// small decode helpers.
package pipe_pkg;

    // NOP encoding issued in place of wrong-path instructions; it has no
    // register or memory side effects downstream.
    localparam logic [31:0] BUBBLE_INST = 32'hD503201F;

    // Opcode match constants, aligned to the top of the instruction word.
    localparam logic [5:0]  OP_B     = 6'b000101;       // inst[31:26]
    localparam logic [5:0]  OP_BL    = 6'b100101;       // inst[31:26]
    localparam logic [7:0]  OP_BCOND = 8'b01010100;     // inst[31:24]
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;     // inst[31:24]
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;  // inst[31:22]
    localparam logic [10:0] OP_BR    = 11'b11010110000; // inst[31:21]
    localparam logic [10:0] OP_LDUR  = 11'b11111000010; // inst[31:21]
    localparam logic [10:0] OP_STUR  = 11'b11111000000; // inst[31:21]
    localparam logic [10:0] OP_ADDS  = 11'b10101011000; // inst[31:21]
    localparam logic [10:0] OP_SUBS  = 11'b11101011000; // inst[31:21]

    localparam int IMM26_W = 26;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } fetch_state_t;

    typedef enum logic [3:0] {
        OPC_OTHER = 4'd0,
        OPC_B     = 4'd1,
        OPC_BL    = 4'd2,
        OPC_BCOND = 4'd3,
        OPC_CBZ   = 4'd4,
        OPC_BR    = 4'd5,
        OPC_LDUR  = 4'd6,
        OPC_STUR  = 4'd7,
        OPC_ADDI  = 4'd8,
        OPC_ADDS  = 4'd9,
        OPC_SUBS  = 4'd10
    } op_class_t;

    // Classify an instruction word by its opcode field; shared with control
    // so both stages agree on the encodings.
    function automatic op_class_t classify_opcode(input logic [31:0] inst);
        op_class_t cls;
        cls = OPC_OTHER;
        if (inst[31:26] == OP_B)
            cls = OPC_B;
        else if (inst[31:26] == OP_BL)
            cls = OPC_BL;
        else if (inst[31:24] == OP_BCOND)
            cls = OPC_BCOND;
        else if (inst[31:24] == OP_CBZ)
            cls = OPC_CBZ;
        else if (inst[31:22] == OP_ADDI)
            cls = OPC_ADDI;
        else if (inst[31:21] == OP_BR)
            cls = OPC_BR;
        else if (inst[31:21] == OP_LDUR)
            cls = OPC_LDUR;
        else if (inst[31:21] == OP_STUR)
            cls = OPC_STUR;
        else if (inst[31:21] == OP_ADDS)
            cls = OPC_ADDS;
        else if (inst[31:21] == OP_SUBS)
            cls = OPC_SUBS;
        return cls;
    endfunction

    // Select the branch immediate field and sign-extend it to 26 bits:
    // imm19 lives in [23:5] for B.cond/CBZ, imm26 in [25:0] for B/BL.
    function automatic logic [IMM26_W-1:0] branch_imm(input logic [25:0] field,
                                                      input logic cond);
        logic [IMM26_W-1:0] imm;
        if (cond)
            imm = {{7{field[23]}}, field[23:5]};
        else
            imm = field;
        return imm;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: either the register branch target, or the
// PC of the branch plus its sign-extended word offset.
module pc_target_calc
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] inst_pc,
    input  logic [25:0]       imm_field,
    input  logic              cond,
    input  logic              BR,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] target
);

    logic [IMM26_W-1:0] imm;
    logic [ADDR_W-1:0]  offset;

    // Sign-extend the word offset to full width before scaling to bytes,
    // so backward branches wrap correctly modulo 2^ADDR_W.
    always_comb begin
        imm    = branch_imm(imm_field, cond);
        offset = {{(ADDR_W - IMM26_W){imm[IMM26_W-1]}}, imm} << 2;
        if (BR)
            target = br_target;
        else
            target = inst_pc + offset;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers the fetched word with its
// PC for the control stage, and applies branch redirects by squashing the
// wrong-path fetches with bubbles.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int          ADDR_W        = 64,
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int          SQUASH_CYCLES = 1,
    parameter logic [31:0] BUBBLE        = BUBBLE_INST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              takeB,
    input  logic              cond,
    input  logic              BR,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              inst_valid
);

    // The redirect edge itself issues the first bubble, so the counter only
    // covers the remaining SQUASH_CYCLES-1 bubbles.
    localparam logic [2:0]        SQUASH_INIT = 3'(SQUASH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_INIT     = ADDR_W'(RESET_PC);

    fetch_state_t      state, state_next;
    logic [2:0]        count, count_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [31:0]       instruction_next;
    logic [ADDR_W-1:0] inst_pc_next;
    logic              inst_valid_next;
    logic [ADDR_W-1:0] target;
    logic              redirect;

    pc_target_calc #(
        .ADDR_W(ADDR_W)
    ) u_target (
        .inst_pc  (inst_pc),
        .imm_field(instruction[25:0]),
        .cond     (cond),
        .BR       (BR),
        .br_target(br_target),
        .target   (target)
    );

    assign imem_addr = pc;
    assign link_addr = inst_pc + PC_STEP;

    // Branch decisions only refer to real instructions; a bubble in the
    // decode slot can never redirect.
    assign redirect = inst_valid && (BR || takeB);

    // Next-state logic: redirect outranks stall, stall freezes everything,
    // otherwise fetch the word at PC; SQUASH walks the PC past wrong-path
    // words while issuing bubbles and ignores stall and branch inputs.
    always_comb begin
        state_next       = state;
        count_next       = count;
        pc_next          = pc;
        instruction_next = instruction;
        inst_pc_next     = inst_pc;
        inst_valid_next  = inst_valid;
        case (state)
            RUN: begin
                if (redirect) begin
                    pc_next          = target;
                    instruction_next = BUBBLE;
                    inst_valid_next  = 1'b0;
                    if (SQUASH_CYCLES > 1) begin
                        state_next = SQUASH;
                        count_next = SQUASH_INIT;
                    end
                end else if (!stall) begin
                    instruction_next = imem_rdata;
                    inst_pc_next     = pc;
                    inst_valid_next  = 1'b1;
                    pc_next          = pc + PC_STEP;
                end
            end
            SQUASH: begin
                pc_next          = pc + PC_STEP;
                instruction_next = BUBBLE;
                inst_valid_next  = 1'b0;
                count_next       = count - 3'd1;
                if (count <= 3'd1)
                    state_next = RUN;
            end
            default: begin
                state_next = RUN;
                count_next = 3'd0;
            end
        endcase
    end

    // State registers; reset abandons any squash in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            count       <= 3'd0;
            pc          <= PC_INIT;
            instruction <= BUBBLE;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            pc          <= pc_next;
            instruction <= instruction_next;
            inst_pc     <= inst_pc_next;
            inst_valid  <= inst_valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: u_dut0 uses a single squash bubble,
// u_dut1 uses three; each has its own reset and control inputs.
module tb_fetch_stage;
    import pipe_pkg::*;

    localparam logic [31:0] W_ADDI = 32'h91000421;
    localparam logic [31:0] W_B4   = 32'h14000004;
    localparam logic [31:0] W_BLT  = 32'h54FFFF8B;
    localparam logic [31:0] W_ADD  = 32'h8B020020;
    localparam logic [31:0] W_BUB  = 32'hD503201F;

    logic clk = 1'b0;

    logic        reset0, stall0, take_b0, cond0, br0;
    logic [63:0] br_target0, imem_addr0, inst_pc0, link_addr0;
    logic [31:0] imem_rdata0, instruction0;
    logic        inst_valid0;

    logic        reset1, stall1, take_b1, cond1, br1;
    logic [63:0] br_target1, imem_addr1, inst_pc1, link_addr1;
    logic [31:0] imem_rdata1, instruction1;
    logic        inst_valid1;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Small instruction memory: a few branch words at fixed addresses.
    function automatic logic [31:0] imem_model(input logic [63:0] addr);
        logic [31:0] w;
        case (addr)
            64'h20:  w = W_B4;
            64'h30:  w = W_ADD;
            64'h40:  w = W_BLT;
            default: w = W_ADDI;
        endcase
        return w;
    endfunction

    assign imem_rdata0 = imem_model(imem_addr0);
    assign imem_rdata1 = imem_model(imem_addr1);

    fetch_stage #(
        .ADDR_W(64), .RESET_PC(64'h0), .SQUASH_CYCLES(1), .BUBBLE(W_BUB)
    ) u_dut0 (
        .clk(clk), .reset(reset0), .stall(stall0), .takeB(take_b0),
        .cond(cond0), .BR(br0), .br_target(br_target0),
        .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
        .instruction(instruction0), .inst_pc(inst_pc0),
        .link_addr(link_addr0), .inst_valid(inst_valid0)
    );

    fetch_stage #(
        .ADDR_W(64), .RESET_PC(64'h0), .SQUASH_CYCLES(3), .BUBBLE(W_BUB)
    ) u_dut1 (
        .clk(clk), .reset(reset1), .stall(stall1), .takeB(take_b1),
        .cond(cond1), .BR(br1), .br_target(br_target1),
        .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .instruction(instruction1), .inst_pc(inst_pc1),
        .link_addr(link_addr1), .inst_valid(inst_valid1)
    );

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic apply_stimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_dut0(input string tag, input logic [31:0] e_inst,
                              input logic [63:0] e_pc, input logic e_valid,
                              input logic [63:0] e_addr);
        check_output({tag, ".instruction"}, 64'(instruction0), 64'(e_inst));
        check_output({tag, ".inst_pc"}, inst_pc0, e_pc);
        check_output({tag, ".inst_valid"}, 64'(inst_valid0), 64'(e_valid));
        check_output({tag, ".imem_addr"}, imem_addr0, e_addr);
    endtask

    task automatic check_dut1(input string tag, input logic [31:0] e_inst,
                              input logic [63:0] e_pc, input logic e_valid,
                              input logic [63:0] e_addr);
        check_output({tag, ".instruction"}, 64'(instruction1), 64'(e_inst));
        check_output({tag, ".inst_pc"}, inst_pc1, e_pc);
        check_output({tag, ".inst_valid"}, 64'(inst_valid1), 64'(e_valid));
        check_output({tag, ".imem_addr"}, imem_addr1, e_addr);
    endtask

    initial begin
        reset0 = 1'b1; stall0 = 1'b0; take_b0 = 1'b0; cond0 = 1'b0;
        br0 = 1'b0; br_target0 = 64'h0;
        reset1 = 1'b1; stall1 = 1'b0; take_b1 = 1'b0; cond1 = 1'b0;
        br1 = 1'b0; br_target1 = 64'h0;

        // Reset state
        #2;
        check_dut0("rst", W_BUB, 64'h0, 1'b0, 64'h0);
        check_output("rst.link_addr", link_addr0, 64'h4);
        apply_stimulus(1);
        reset0 = 1'b0;

        // Sequential fetch of ADDI words
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1);
            check_dut0($sformatf("seq%0d", i), W_ADDI, 64'(i * 4), 1'b1, 64'(i * 4 + 4));
        end
        check_output("seq.imem_addr_10", imem_addr0, 64'h10);

        // B +4 at 0x20, taken with imm26
        apply_stimulus(5);
        check_dut0("b_fetch", W_B4, 64'h20, 1'b1, 64'h24);
        take_b0 = 1'b1; cond0 = 1'b0;
        apply_stimulus(1);
        check_dut0("b_redirect", W_BUB, 64'h20, 1'b0, 64'h30);
        apply_stimulus(1);
        check_dut0("b_target", W_ADD, 64'h30, 1'b1, 64'h34);
        check_output("b_target.link_addr", link_addr0, 64'h34);
        take_b0 = 1'b0;

        // B.LT -4 at 0x40, taken with imm19
        apply_stimulus(4);
        check_dut0("blt_fetch", W_BLT, 64'h40, 1'b1, 64'h44);
        take_b0 = 1'b1; cond0 = 1'b1;
        apply_stimulus(1);
        check_dut0("blt_redirect", W_BUB, 64'h40, 1'b0, 64'h30);
        take_b0 = 1'b0; cond0 = 1'b0;
        apply_stimulus(1);
        check_dut0("blt_target", W_ADD, 64'h30, 1'b1, 64'h34);

        // BR together with stall: redirect wins once, then stall holds
        br0 = 1'b1; br_target0 = 64'h1000; stall0 = 1'b1;
        apply_stimulus(1);
        check_dut0("br_stall", W_BUB, 64'h30, 1'b0, 64'h1000);
        br0 = 1'b0;
        apply_stimulus(1);
        check_dut0("br_hold", W_BUB, 64'h30, 1'b0, 64'h1000);
        stall0 = 1'b0;
        apply_stimulus(1);
        check_dut0("br_fetch", W_ADDI, 64'h1000, 1'b1, 64'h1004);
        stall0 = 1'b1;
        apply_stimulus(1);
        check_dut0("stall_hold", W_ADDI, 64'h1000, 1'b1, 64'h1004);
        stall0 = 1'b0;

        // BR to the top of the address space: PC wraps to zero
        br0 = 1'b1; br_target0 = 64'hFFFF_FFFF_FFFF_FFFC;
        apply_stimulus(1);
        check_dut0("wrap_redirect", W_BUB, 64'h1000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        br0 = 1'b0;
        apply_stimulus(1);
        check_dut0("wrap_fetch", W_ADDI, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h0);
        check_output("wrap.link_addr", link_addr0, 64'h0);

        // Three-bubble squash with takeB pulsed during the bubbles
        reset1 = 1'b0;
        apply_stimulus(9);
        check_dut1("sq_fetch", W_B4, 64'h20, 1'b1, 64'h24);
        take_b1 = 1'b1;
        apply_stimulus(1);
        check_dut1("sq_bub1", W_BUB, 64'h20, 1'b0, 64'h30);
        apply_stimulus(1);
        check_dut1("sq_bub2", W_BUB, 64'h20, 1'b0, 64'h34);
        apply_stimulus(1);
        check_dut1("sq_bub3", W_BUB, 64'h20, 1'b0, 64'h38);
        take_b1 = 1'b0;
        apply_stimulus(1);
        check_dut1("sq_resume", W_ADDI, 64'h38, 1'b1, 64'h3C);

        // Reset in the middle of a squash
        apply_stimulus(2);
        check_dut1("sq2_fetch", W_BLT, 64'h40, 1'b1, 64'h44);
        take_b1 = 1'b1; cond1 = 1'b1;
        apply_stimulus(1);
        check_dut1("sq2_bub1", W_BUB, 64'h40, 1'b0, 64'h30);
        take_b1 = 1'b0; cond1 = 1'b0;
        apply_stimulus(1);
        check_dut1("sq2_bub2", W_BUB, 64'h40, 1'b0, 64'h34);
        reset1 = 1'b1;
        #1;
        check_dut1("mid_rst", W_BUB, 64'h0, 1'b0, 64'h0);
        apply_stimulus(1);
        reset1 = 1'b0;
        apply_stimulus(1);
        check_dut1("post_rst0", W_ADDI, 64'h0, 1'b1, 64'h4);
        apply_stimulus(1);
        check_dut1("post_rst1", W_ADDI, 64'h4, 1'b1, 64'h8);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
